// File: rtl/mux_arbiter_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package mux_arbiter_pkg;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_t;

    // Requester 0 wins the first tie after reset.
    localparam logic ARB_RESET_LAST_GRANT = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way grant picker; MUX_ARBITER_ROUND_ROBIN_EN selects
// round-robin tie breaking, otherwise requester 0 wins every tie.
module arb_pick2
    import mux_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic any_req
);

    // Grant selection; with no request the grant parks on last_grant.
    always_comb begin
        grant   = last_grant;
        any_req = valid0 | valid1;
        case ({valid1, valid0})
            2'b01: grant = 1'b0;
            2'b10: grant = 1'b1;
            2'b11: begin
`ifdef MUX_ARBITER_ROUND_ROBIN_EN
                grant = ~last_grant;
`else
                grant = 1'b0;
`endif
            end
            default: grant = last_grant;
        endcase
    end

endmodule

// File: rtl/mux_arbiter.sv
// Two-source valid/ready arbiter driving a shared 2:1 mux into a one-entry
// output register. Tie policy set by MUX_ARBITER_ROUND_ROBIN_EN (in arb_pick2).
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in0_valid,
    input  logic [N-1:0] in0_data,
    output logic         in0_ready,
    input  logic         in1_valid,
    input  logic [N-1:0] in1_data,
    output logic         in1_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_src,
    input  logic         out_ready,
    output logic         select
);

    arb_state_t   state_r;
    arb_state_t   state_next_s;
    logic         last_grant_r;
    logic [N-1:0] out_data_r;
    logic         out_src_r;
    logic         grant_s;
    logic         any_req_s;
    logic         can_load_s;
    logic         xfer_s;
    logic         in0_ready_s;
    logic         in1_ready_s;
    logic [N-1:0] mux_data_s;

    arb_pick2 u_pick (
        .valid0     (in0_valid),
        .valid1     (in1_valid),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .any_req    (any_req_s)
    );

    // Load gating and ready generation; readies are held low during reset.
    always_comb begin
        can_load_s  = (state_r == ARB_EMPTY) | out_ready;
        xfer_s      = 1'b0;
        in0_ready_s = 1'b0;
        in1_ready_s = 1'b0;
        if (rst_n) begin
            xfer_s      = can_load_s & any_req_s;
            in0_ready_s = xfer_s & (grant_s == 1'b0) & in0_valid;
            in1_ready_s = xfer_s & (grant_s == 1'b1) & in1_valid;
        end else begin
            xfer_s      = 1'b0;
            in0_ready_s = 1'b0;
            in1_ready_s = 1'b0;
        end
        mux_data_s = grant_s ? in1_data : in0_data;
    end

    // Next-state logic: a load always wins over a drain in the same cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ARB_EMPTY: begin
                if (xfer_s) begin
                    state_next_s = ARB_FULL;
                end else begin
                    state_next_s = ARB_EMPTY;
                end
            end
            ARB_FULL: begin
                if (xfer_s) begin
                    state_next_s = ARB_FULL;
                end else if (out_ready) begin
                    state_next_s = ARB_EMPTY;
                end else begin
                    state_next_s = ARB_FULL;
                end
            end
            default: state_next_s = ARB_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output register and grant history, updated only on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r   <= {N{1'b0}};
            out_src_r    <= 1'b0;
            last_grant_r <= ARB_RESET_LAST_GRANT;
        end else if (xfer_s) begin
            out_data_r   <= mux_data_s;
            out_src_r    <= grant_s;
            last_grant_r <= grant_s;
        end
    end

    assign in0_ready = in0_ready_s;
    assign in1_ready = in1_ready_s;
    assign out_valid = (state_r == ARB_FULL);
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign select    = grant_s;

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-requester arbiter that shares a single N-bit 2:1 mux datapath between two valid/ready sources and registers the winner onto one valid/ready output. It owns the mux select: each cycle it decides which input, if any, is steered through the mux, then captures the result in a one-entry output register. It sits between two producers and one consumer wherever the design time-multiplexes a shared path.

## Interface
- `N`, default 8: data width in bits for the inputs and the output.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in0_valid` input 1: requester 0 has data.
- `in0_data` input N: requester 0 payload.
- `in0_ready` output 1: requester 0 transfer accepted this cycle.
- `in1_valid` input 1: requester 1 has data.
- `in1_data` input N: requester 1 payload.
- `in1_ready` output 1: requester 1 transfer accepted this cycle.
- `out_valid` output 1: the output register holds data.
- `out_data` output N: registered mux result.
- `out_src` output 1: which requester `out_data` came from (0 or 1).
- `out_ready` input 1: consumer accepts `out_data` this cycle.
- `select` output 1: current mux select; combinational, equal to the grant.

## Operation
- The state machine has two states:
  - EMPTY: the output register holds no data.
  - FULL: the output register holds data.
- Load condition is `can_load = (state==EMPTY) | out_ready`. Draining and loading in the same cycle is legal.
- Grant is combinational from `in0_valid`, `in1_valid` and `last_grant`:
  - Only one valid: that requester wins.
  - Both valid: the winner is `~last_grant` (round-robin).
  - Neither valid: no grant, and `select` holds `last_grant`.
- `inX_ready = can_load & grant==X & inX_valid`. At most one ready is high per cycle.
- A transfer on input X occurs when `inX_valid & inX_ready`. On the clock edge:
  - `out_data <= select ? in1_data : in0_data`.
  - `out_src <= X`.
  - `last_grant <= X`.
  - The state goes to FULL.
- Output handshake: `out_valid & out_ready` with no input transfer in the same cycle sends the state to EMPTY. `out_data` and `out_src` hold their last values.
- While FULL and `out_ready` is low, `out_data` and `out_src` are stable and both input readies are 0 (backpressure).
- Requesters must hold `valid` and `data` stable until their ready is seen. The block does not check this.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `out_valid`=0, `out_data`=0, `out_src`=0.
  - `last_grant`=1, so requester 0 wins the first tie.
  - State is EMPTY.
  - `in0_ready` and `in1_ready` are forced to 0 while `rst_n` is low.
- Latency: an input transfer in cycle t gives `out_valid`=1 with that data in cycle t+1.
- Throughput: one transfer per cycle when `out_ready` is held high. Under sustained contention the grants alternate 0,1,0,1.
- Simultaneous drain and load: `out_valid` stays 1 and the new data replaces the old on the same edge, with no bubble.
- Reset asserted mid-operation: the held output is discarded, the next `rst_n` rise behaves as power-on, and no partial transfer is reported.
- `select` is valid during any cycle where an input transfer occurs. Its value is don't-care for correctness otherwise, but it must be deterministic: it holds `last_grant`.

## Configuration
- Macro: `MUX_ARBITER_ROUND_ROBIN_EN`.
- Defined: ties resolve round-robin as described above.
- Undefined: fixed priority, and requester 0 always wins a tie.
  - Requester 1 can starve.
  - `last_grant` is still tracked and still drives the idle `select`.
- All other behaviour and timing are identical in both builds.

## Structure
- Shared package `mux_arbiter_pkg` contains:
  - `typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_t`.
  - `localparam logic ARB_RESET_LAST_GRANT = 1'b1`.
- One sub-module, `arb_pick2`, is natural:
  - Purely combinational.
  - Inputs: the two valids and `last_grant`.
  - Outputs: `grant`, `any_req`.
  - Holds the only `ifdef` on `MUX_ARBITER_ROUND_ROBIN_EN`.
- The top level holds the state register, the output register and the ready gating.

## Test plan
- **Reset:** hold `rst_n`=0 with both valids high and `in0_data`=8'hAA → both readies 0, `out_valid`=0, `out_data`=8'h00. After release, the first edge loads 8'hAA with `out_src`=0.
- **Single requester stream:** `in1_valid`=1 with data 8'h11, 8'h22, 8'h33 and `out_ready`=1 → `out_data` shows 8'h11, 8'h22, 8'h33 on consecutive cycles, `out_src`=1, no bubbles.
- **Contention, round-robin build:** both valid continuously, in0 data 8'h0n, in1 data 8'h1n, `out_ready`=1 → out sequence 8'h00, 8'h10, 8'h01, 8'h11, … Without the macro → 8'h00, 8'h01, 8'h02, … and `in1_ready` never asserts.
- **Backpressure:** load 8'h5A, then `out_ready`=0 for 3 cycles with both valid → `out_data` stays 8'h5A, readies stay 0. When `out_ready` rises, drain and load happen on the same edge.
- **Reset mid-operation:** FULL with 8'hC3 and `out_ready`=0, pulse `rst_n` low asynchronously between edges → `out_valid` drops immediately, and the next tie grants requester 0.
- **Idle gaps:** alternate valid-high and valid-low cycles on in0 only → `out_valid` toggles with one-cycle latency, and `select` stays 0 throughout.
